// File: rtl/matmul_pkg.sv
// Shared constants, CONTROL field layout and sequencer states for the matmul controller.
package matmul_pkg;

   localparam int BUS_WIDTH   = 32;
   localparam int ADDR_WIDTH  = 16;
   localparam int MAX_DIM     = 4;
   localparam int SP_NTARGETS = 4;

   localparam int DIM_W = $clog2(MAX_DIM);
   localparam int TGT_W = $clog2(SP_NTARGETS);
   localparam int CNT_W = DIM_W + 1;

   localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = 16'h0000;
   localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = 16'h0004;
   localparam logic [ADDR_WIDTH-1:0] PERF_ADDR   = 16'h0008;

   localparam int CTRL_START   = 0;
   localparam int CTRL_BIAS    = 1;
   localparam int CTRL_TGT_LSB = 2;
   localparam int CTRL_M_LSB   = 8;
   localparam int CTRL_K_LSB   = 10;
   localparam int CTRL_N_LSB   = 12;

   typedef enum logic [2:0] {IDLE, FEED, DRAIN, WRITE, DONE} state_t;

   // Storable CONTROL bits; start is a strobe and never held.
   function automatic logic [BUS_WIDTH-1:0] ctrl_rw_mask();
      logic [BUS_WIDTH-1:0] m;
      m = '0;
      m[CTRL_BIAS] = 1'b1;
      m[CTRL_TGT_LSB +: TGT_W] = '1;
      m[CTRL_M_LSB +: DIM_W] = '1;
      m[CTRL_K_LSB +: DIM_W] = '1;
      m[CTRL_N_LSB +: DIM_W] = '1;
      return m;
   endfunction

   localparam logic [BUS_WIDTH-1:0] CTRL_RW_MASK = ctrl_rw_mask();

endpackage

// File: rtl/matmul_ctrl_if.sv
// APB slave bus bundle for the matmul controller.
interface matmul_ctrl_if;
   import matmul_pkg::*;

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [MAX_DIM-1:0]    pstrb;
   logic [BUS_WIDTH-1:0]  pwdata;
   logic [ADDR_WIDTH-1:0] paddr;
   logic                  pready;
   logic                  pslverr;
   logic [BUS_WIDTH-1:0]  prdata;

   modport master (
      output psel, penable, pwrite, pstrb, pwdata, paddr,
      input  pready, pslverr, prdata
   );

   modport slave (
      input  psel, penable, pwrite, pstrb, pwdata, paddr,
      output pready, pslverr, prdata
   );

endinterface

// File: rtl/matmul_apb_regs.sv
// APB decode, CONTROL register with byte strobes, error response and read mux.
// PERF register exists only when MATMUL_CTRL_PERF_EN is defined.
module matmul_apb_regs
   import matmul_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   matmul_ctrl_if.slave     apb,
   input  logic             busy,
   input  logic             done,
   input  logic             ovf,
`ifdef MATMUL_CTRL_PERF_EN
   input  logic [BUS_WIDTH-1:0] perf_cnt,
`endif
   output logic             start,
   output logic             bias,
   output logic [TGT_W-1:0] target,
   output logic [DIM_W-1:0] m_last,
   output logic [DIM_W-1:0] k_last,
   output logic [DIM_W-1:0] n_last
);

   logic [BUS_WIDTH-1:0] ctrl_q;
   logic [BUS_WIDTH-1:0] lane_mask;
   logic [BUS_WIDTH-1:0] status_word;
   logic access, hit_ctrl, hit_status, hit_perf, mapped, wr_ctrl;

   assign access     = apb.psel && apb.penable;
   assign hit_ctrl   = (apb.paddr == CTRL_ADDR);
   assign hit_status = (apb.paddr == STATUS_ADDR);
`ifdef MATMUL_CTRL_PERF_EN
   assign hit_perf   = (apb.paddr == PERF_ADDR);
`else
   assign hit_perf   = 1'b0;
`endif
   assign mapped     = hit_ctrl || hit_status || hit_perf;

   // Writes while an operation runs are refused so the latched dimensions stay stable.
   assign wr_ctrl     = access && apb.pwrite && hit_ctrl && !busy;
   assign apb.pready  = access;
   assign apb.pslverr = access && (!mapped || (apb.pwrite && (!hit_ctrl || busy)));

   for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
      assign lane_mask[8*i +: 8] = {8{apb.pstrb[i]}};
   end

   always_ff @(posedge clk) begin
      if (!rst)
         ctrl_q <= '0;
      else if (wr_ctrl)
         ctrl_q <= (ctrl_q & ~lane_mask) | (apb.pwdata & lane_mask & CTRL_RW_MASK);
   end

   assign start  = wr_ctrl && apb.pstrb[0] && apb.pwdata[CTRL_START];
   assign bias   = ctrl_q[CTRL_BIAS];
   assign target = ctrl_q[CTRL_TGT_LSB +: TGT_W];
   assign m_last = ctrl_q[CTRL_M_LSB +: DIM_W];
   assign k_last = ctrl_q[CTRL_K_LSB +: DIM_W];
   assign n_last = ctrl_q[CTRL_N_LSB +: DIM_W];

   assign status_word = {{(BUS_WIDTH-3){1'b0}}, ovf, done, busy};

   always_comb begin
      apb.prdata = '0;
      if (access && !apb.pwrite && mapped) begin
         if (hit_ctrl)   apb.prdata = ctrl_q;
         if (hit_status) apb.prdata = status_word;
`ifdef MATMUL_CTRL_PERF_EN
         if (hit_perf)   apb.prdata = perf_cnt;
`endif
      end
   end

endmodule

// File: rtl/matmul_ctrl.sv
// Matmul sequencer: FEED -> DRAIN -> WRITE -> DONE driven from APB CONTROL writes.
// Optional busy-cycle counter at 0x08 when MATMUL_CTRL_PERF_EN is defined.
module matmul_ctrl
   import matmul_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   matmul_ctrl_if.slave     apb,
   output logic             busy,
   output logic             done,
   output logic             dp_clear,
   output logic             dp_feed_en,
   output logic [DIM_W-1:0] dp_feed_idx,
   output logic             dp_en,
   input  logic             dp_ovf,
   output logic             res_wr_en,
   output logic [DIM_W-1:0] res_row,
   output logic [TGT_W-1:0] res_target,
   output logic             bias_en
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] drain_last;
   logic             done_q, ovf_q;
   logic             start, bias;
   logic [TGT_W-1:0] target;
   logic [DIM_W-1:0] m_last, k_last, n_last;

`ifdef MATMUL_CTRL_PERF_EN
   logic [BUS_WIDTH-1:0] perf_q;
`endif

   matmul_apb_regs u_regs (
      .clk      (clk),
      .rst      (rst),
      .apb      (apb),
      .busy     (busy),
      .done     (done_q),
      .ovf      (ovf_q),
`ifdef MATMUL_CTRL_PERF_EN
      .perf_cnt (perf_q),
`endif
      .start    (start),
      .bias     (bias),
      .target   (target),
      .m_last   (m_last),
      .k_last   (k_last),
      .n_last   (n_last)
   );

   assign busy = (state_q != IDLE);
   assign done = done_q;

   // Drain covers M+N-1 cycles, so the last count is (M-1)+(N-1).
   assign drain_last = {1'b0, m_last} + {1'b0, n_last};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dp_clear    = 1'b0;
      dp_feed_en  = 1'b0;
      dp_feed_idx = '0;
      dp_en       = 1'b0;
      res_wr_en   = 1'b0;
      res_row     = '0;
      res_target  = '0;
      bias_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FEED;
               cnt_d   = '0;
            end
         end
         FEED: begin
            dp_en       = 1'b1;
            dp_feed_en  = 1'b1;
            dp_feed_idx = cnt_q[DIM_W-1:0];
            dp_clear    = (cnt_q == '0) && !bias;
            if (cnt_q == {1'b0, k_last}) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            dp_en = 1'b1;
            if (cnt_q == drain_last) begin
               state_d = WRITE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WRITE: begin
            res_wr_en  = 1'b1;
            res_row    = cnt_q[DIM_W-1:0];
            res_target = target;
            bias_en    = bias;
            if (cnt_q == {1'b0, m_last}) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (start) begin
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (state_q == WRITE && state_d == DONE)
            done_q <= 1'b1;
         if ((state_q == FEED || state_q == DRAIN) && dp_ovf)
            ovf_q <= 1'b1;
      end
   end

`ifdef MATMUL_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst)
         perf_q <= '0;
      else if (start)
         perf_q <= '0;
      else if (busy && perf_q != '1)
         perf_q <= perf_q + BUS_WIDTH'(1);
   end
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: register table, directed sequences, random operations.
module tb_matmul_ctrl;
   import matmul_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic dp_ovf = 1'b0;
   logic busy, done, dp_clear, dp_feed_en, dp_en, res_wr_en, bias_en;
   logic [DIM_W-1:0] dp_feed_idx, res_row;
   logic [TGT_W-1:0] res_target;

   matmul_ctrl_if bus();

   matmul_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .apb         (bus),
      .busy        (busy),
      .done        (done),
      .dp_clear    (dp_clear),
      .dp_feed_en  (dp_feed_en),
      .dp_feed_idx (dp_feed_idx),
      .dp_en       (dp_en),
      .dp_ovf      (dp_ovf),
      .res_wr_en   (res_wr_en),
      .res_row     (res_row),
      .res_target  (res_target),
      .bias_en     (bias_en)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] CTRL_MASK = 32'h0000_3F0E;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       clr;
      logic       fen;
      logic [1:0] fidx;
      logic       en;
      logic       wr;
      logic [1:0] row;
      logic [1:0] tgt;
      logic       bias;
   } obs_t;

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        err;
      logic [31:0] rd;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   obs_t        exp_q[$];
   vec_t        tbl[$];
   logic [31:0] ctrl_m = '0;
   logic        op_active = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o = {busy, done, dp_clear, dp_feed_en, dp_feed_idx, dp_en, res_wr_en,
           res_row, res_target, bias_en};
      return o;
   endfunction

   // Called at a falling edge; returns at the falling edge after the access phase.
   task automatic apb(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic err);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w;
      bus.paddr = a; bus.pwdata = d; bus.pstrb = s;
      @(negedge clk);
      bus.penable = 1'b1;
      #1;
      rd  = bus.prdata;
      err = bus.pslverr;
      check("pready", 32'(bus.pready), 32'd1);
      if (w && a == 16'h0 && !op_active)
         for (int i = 0; i < 4; i++)
            if (s[i]) ctrl_m[8*i +: 8] = d[8*i +: 8] & CTRL_MASK[8*i +: 8];
      @(negedge clk);
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
   endtask

   task automatic run_op(input int m1, input int k1, input int n1, input logic bias,
                         input int tgt, input int ovf_cyc, input int bw_cyc);
      int M, K, N, L;
      obs_t o;
      logic [31:0] rd, d;
      logic err, exp_ovf;
      M = m1 + 1; K = k1 + 1; N = n1 + 1;
      exp_q.delete();
      for (int k = 0; k < K; k++) begin
         o = '0; o.busy = 1'b1; o.clr = (k == 0) && !bias; o.fen = 1'b1;
         o.fidx = 2'(k); o.en = 1'b1;
         exp_q.push_back(o);
      end
      for (int i = 0; i < M + N - 1; i++) begin
         o = '0; o.busy = 1'b1; o.en = 1'b1;
         exp_q.push_back(o);
      end
      for (int r = 0; r < M; r++) begin
         o = '0; o.busy = 1'b1; o.wr = 1'b1; o.row = 2'(r); o.tgt = 2'(tgt); o.bias = bias;
         exp_q.push_back(o);
      end
      o = '0; o.busy = 1'b1; o.done = 1'b1;
      exp_q.push_back(o);
      L = exp_q.size();
      exp_ovf = (ovf_cyc >= 1) && (ovf_cyc <= K + M + N - 1);

      d = (32'(n1) << 12) | (32'(k1) << 10) | (32'(m1) << 8) | (32'(tgt) << 2)
          | (32'(bias) << 1) | 32'd1;
      apb(1'b1, 16'h0, d, 4'hF, rd, err);
      check("start_err", 32'(err), 32'd0);
      op_active = 1'b1;
      for (int c = 1; c <= L; c++) begin
         check($sformatf("trace_c%0d", c), 32'(sample()), 32'(exp_q[c-1]));
         dp_ovf = (c == ovf_cyc);
         if (bw_cyc > 0 && c == bw_cyc) begin
            bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
            bus.paddr = 16'h0; bus.pwdata = 32'h0000_000F; bus.pstrb = 4'hF;
         end
         if (bw_cyc > 0 && c == bw_cyc + 1) begin
            bus.penable = 1'b1;
            #1;
            check("busy_wr_err", 32'(bus.pslverr), 32'd1);
         end
         if (bw_cyc > 0 && c == bw_cyc + 2) begin
            bus.psel = 1'b0; bus.penable = 1'b0;
         end
         @(negedge clk);
      end
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; dp_ovf = 1'b0;
      op_active = 1'b0;
      o = '0; o.done = 1'b1;
      check("idle_after", 32'(sample()), 32'(o));
      apb(1'b0, 16'h4, '0, 4'h0, rd, err);
      check("status", rd, {29'd0, exp_ovf, 1'b1, 1'b0});
      apb(1'b0, 16'h0, '0, 4'h0, rd, err);
      check("ctrl_rd", rd, ctrl_m);
`ifdef MATMUL_CTRL_PERF_EN
      apb(1'b0, 16'h8, '0, 4'h0, rd, err);
      check("perf", rd, 32'(L));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic err;
      logic seen_wr;
      int m1, k1, n1, tg, L, oc, bw;
      logic bs;

      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
      repeat (3) @(negedge clk);
      check("reset_obs", 32'(sample()), 32'd0);
      check("reset_pready", 32'(bus.pready), 32'd0);
      check("reset_pslverr", 32'(bus.pslverr), 32'd0);
      check("reset_prdata", bus.prdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      tbl.push_back('{1'b0, 16'h0000, 32'h0,         4'h0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 16'h0004, 32'h0,         4'h0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 16'h000C, 32'h0,         4'h0, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 16'h0004, 32'h5,         4'hF, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 16'h0000, 32'h0000_3F0E, 4'h1, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 16'h0000, 32'h0,         4'h0, 1'b0, 32'h0000_000E});
      tbl.push_back('{1'b1, 16'h0000, 32'h0000_0500, 4'h2, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 16'h0000, 32'h0,         4'h0, 1'b0, 32'h0000_050E});
      tbl.push_back('{1'b1, 16'h0000, 32'hFFFF_FFF0, 4'hC, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 16'h0000, 32'h0,         4'h0, 1'b0, 32'h0000_050E});
      tbl.push_back('{1'b1, 16'h0000, 32'h0000_0001, 4'h2, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 16'h0000, 32'h0,         4'h0, 1'b0, 32'h0000_000E});
      tbl.push_back('{1'b0, 16'h0002, 32'h0,         4'h0, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 16'h1004, 32'h0,         4'h0, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 16'h000C, 32'h1,         4'hF, 1'b1, 32'h0});
`ifdef MATMUL_CTRL_PERF_EN
      tbl.push_back('{1'b0, 16'h0008, 32'h0,         4'h0, 1'b0, 32'h0});
`else
      tbl.push_back('{1'b0, 16'h0008, 32'h0,         4'h0, 1'b1, 32'h0});
`endif
      for (int i = 0; i < tbl.size(); i++) begin
         apb(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, rd, err);
         check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
         check($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
      end
      check("no_start", 32'(busy), 32'd0);

      // 4x4x4 from CONTROL=0x3F01, with a rejected write mid-run
      run_op(3, 3, 3, 1'b0, 0, 0, 3);
      // bias, slot 2, overflow pulse during DRAIN
      run_op(1, 2, 3, 1'b1, 2, 5, 0);

      for (int t = 0; t < 14; t++) begin
         m1 = $urandom_range(0, 3); k1 = $urandom_range(0, 3); n1 = $urandom_range(0, 3);
         tg = $urandom_range(0, 3); bs = 1'($urandom_range(0, 1));
         L = 2 * (m1 + 1) + (k1 + 1) + (n1 + 1);
         oc = $urandom_range(0, L + 1);
         bw = $urandom_range(0, L - 1);
         run_op(m1, k1, n1, bs, tg, oc, bw);
      end

      // Abort by reset two cycles into FEED
      apb(1'b1, 16'h0, 32'h0000_3F01, 4'hF, rd, err);
      @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      ctrl_m = '0;
      @(negedge clk);
      check("post_rst_obs", 32'(sample()), 32'd0);
      seen_wr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (res_wr_en || busy) seen_wr = 1'b1;
         @(negedge clk);
      end
      check("post_rst_quiet", 32'(seen_wr), 32'd0);
      apb(1'b0, 16'h0, '0, 4'h0, rd, err);
      check("post_rst_ctrl", rd, 32'd0);
      apb(1'b0, 16'h4, '0, 4'h0, rd, err);
      check("post_rst_status", rd, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
APB register front-end and sequencing FSM for the matmul datapath (systolic PE array + operand/result scratchpad).
- Decodes APB CONTROL/STATUS accesses and launches an M×K by K×N operation on a start write.
- Steps the array through FEED, DRAIN and result WRITE phases, then reports completion on busy/done.
- Sits between the APB bus and the PE array / scratchpad.

Parameters:
BUS_WIDTH, 32, APB data width.
ADDR_WIDTH, 16, APB address width.
MAX_DIM, 4, max M/K/N; also pstrb width (one strobe per byte).
SP_NTARGETS, 4, number of scratchpad result slots.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets)
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  APB write
pstrb  in  MAX_DIM  byte write strobes
pwdata  in  BUS_WIDTH  write data
paddr  in  ADDR_WIDTH  byte address
pready  out  1  APB ready
pslverr  out  1  APB error
prdata  out  BUS_WIDTH  read data
busy  out  1  operation in progress
done  out  1  sticky completion flag
dp_clear  out  1  clear PE accumulators (1 cycle)
dp_feed_en  out  1  feed operand slice this cycle
dp_feed_idx  out  $clog2(MAX_DIM)  operand slice index k
dp_en  out  1  PE array advance enable
dp_ovf  in  1  PE overflow indication
res_wr_en  out  1  write result row to scratchpad
res_row  out  $clog2(MAX_DIM)  result row index
res_target  out  $clog2(SP_NTARGETS)  scratchpad result slot
bias_en  out  1  accumulate onto existing result slot

Behaviour:
- Reset (rst==0 at edge): all registers 0, FSM IDLE. Outputs busy, done, dp_*, res_*, bias_en, pslverr, prdata = 0; pready = 0. Reset mid-operation aborts immediately; no further res_wr_en.
- APB timing:
  - Zero wait states: pready = psel&&penable.
  - Write takes effect at the access-phase edge.
  - prdata is combinational from registers when psel&&penable&&!pwrite, else 0.
- Registers:
  - 0x00 CONTROL (rw): bit0 start (self-clearing, reads 0); bit1 bias; [3:2] res_target; [9:8] M-1; [11:10] K-1; [13:12] N-1. Byte lanes are written only where pstrb[i]=1.
  - 0x04 STATUS (ro): bit0 busy, bit1 done, bit2 ovf.
- pslverr=1 in the access phase for:
  - an unmapped address;
  - a write to STATUS;
  - a write to CONTROL while busy (write ignored, registers unchanged).
- Start (CONTROL write with pstrb[0]=1 and pwdata[0]=1, not busy):
  - Next cycle: FEED, busy=1, done and ovf cleared, dp_clear=1 for that first FEED cycle only if bias=0.
- FEED, K cycles: dp_en=1, dp_feed_en=1, dp_feed_idx counts 0..K-1.
- DRAIN, M+N-1 cycles: dp_en=1, dp_feed_en=0.
- WRITE, M cycles: res_wr_en=1, res_row counts 0..M-1, res_target/bias_en held from CONTROL.
- DONE, 1 cycle: done set (sticky until next start), then IDLE, busy=0.
- Latency for M=K=N=4: busy high 16 cycles; done rises on the 16th cycle after the start edge.
- ovf is sticky: set when dp_ovf=1 in FEED or DRAIN.
- Simultaneous STATUS read and state change: returns pre-edge value.
- Dimension fields are latched at start; changes while busy are rejected as above.

Optional Feature:
MATMUL_CTRL_PERF_EN
- Defined: 0x08 PERF (ro) returns busy-cycle count of the last operation.
  - Counter clears on start and saturates at all-ones.
  - A read while busy returns the running count.
- Undefined: no counter; 0x08 is unmapped (pslverr=1).

Decomposition:
- Package matmul_pkg holds:
  - BUS_WIDTH, ADDR_WIDTH, MAX_DIM, SP_NTARGETS;
  - register offsets CTRL_ADDR=0x00, STATUS_ADDR=0x04, PERF_ADDR=0x08;
  - CONTROL field bit positions;
  - state enum {IDLE, FEED, DRAIN, WRITE, DONE}.
- One sub-module: matmul_apb_regs (APB decode, strobes, pslverr, prdata).
- FSM and counters stay in matmul_ctrl.

Test Plan:
- Reset: rst=0 two cycles mid-FEED -> next cycle busy=0, done=0, res_wr_en never asserts, CONTROL reads 0.
- CONTROL=0x3F01, pstrb=4'hF (M=K=N=4):
  - dp_feed_idx 0,1,2,3, then 7 DRAIN cycles;
  - res_row 0..3 with res_target=0;
  - done=1 sixteen cycles after the write edge; STATUS reads 0x2.
- Write CONTROL while busy -> pslverr=1, operation unaffected. Read 0x0C -> pslverr=1, prdata=0.
- Partial strobe: pstrb=4'b0010, pwdata=0x0000_0500 -> M-1=1, K-1=1, other fields unchanged, no start.
- bias=1, res_target=2, dp_ovf pulsed once in DRAIN:
  - no dp_clear;
  - res_target=2 and bias_en=1 during WRITE;
  - STATUS=0x6 after done.
- PERF_EN build: after the 4×4×4 operation, 0x08 reads 16. Non-PERF build: 0x08 gives pslverr=1.
